// File: rtl/resultado_bcd_display_if.sv
// ============================================================================
// Module   : resultado_bcd_display_if
// Purpose  : Divider-result bus and display outputs for resultado_bcd_display.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface resultado_bcd_display_if;
    logic [6:0] cociente;
    logic [6:0] resto;
    logic       done;
    logic [6:0] seg;
    logic [5:0] an;
    logic       busy;
    logic       valid;

    modport master (
        output cociente, resto, done,
        input  seg, an, busy, valid
    );

    modport slave (
        input  cociente, resto, done,
        output seg, an, busy, valid
    );
endinterface

`default_nettype wire

// File: rtl/resultado_bcd_display.sv
// ============================================================================
// Module   : resultado_bcd_display
// Purpose  : Captures divider results, converts them to BCD by double dabble
//            and scans them onto a 6-digit common-anode 7-segment display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module resultado_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    resultado_bcd_display_if.slave  dbus
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [6:0]       bq_q, bq_d, br_q, br_d;
    logic [11:0]      bcdq_q, bcdq_d, bcdr_q, bcdr_d;
    logic [11:0]      dispq_q, dispq_d, dispr_q, dispr_d;
    logic             pend_q, pend_d;
    logic [6:0]       pq_q, pq_d, pr_q, pr_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic             wrap_q, wrap_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;

    logic [18:0]      step_q, step_r;

    // One double-dabble iteration: add-3 correction, then shift {bcd, bin}.
    function automatic logic [18:0] dabble_step(input logic [11:0] bcd, input logic [6:0] bin);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], bin, 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [2:0] idx, input logic [11:0] dq,
                                             input logic [11:0] dr, input logic v);
        logic [11:0] grp;
        logic [3:0]  nib;
        logic        blank;
        grp = (idx >= 3'd3) ? dq : dr;
        case (idx)
            3'd5, 3'd2: begin
                nib   = grp[11:8];
                blank = (grp[11:8] == 4'd0);
            end
            3'd4, 3'd1: begin
                nib   = grp[7:4];
                blank = (grp[11:8] == 4'd0) && (grp[7:4] == 4'd0);
            end
            default: begin
                nib   = grp[3:0];
                blank = 1'b0;
            end
        endcase
        return (!v || blank) ? 7'h7F : seg_code(nib);
    endfunction

    assign step_q = dabble_step(bcdq_q, bq_q);
    assign step_r = dabble_step(bcdr_q, br_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bq_d    = bq_q;
        br_d    = br_q;
        bcdq_d  = bcdq_q;
        bcdr_d  = bcdr_q;
        dispq_d = dispq_q;
        dispr_d = dispr_q;
        pend_d  = pend_q;
        pq_d    = pq_q;
        pr_d    = pr_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        an_d    = an_q;

        // Scan path runs regardless of the conversion FSM.
        if (ref_q == REF_LAST) begin
            ref_d  = '0;
            wrap_d = 1'b1;
        end else begin
            ref_d  = ref_q + REF_W'(1);
            wrap_d = 1'b0;
        end
        if (wrap_q) begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = digit_seg(idx_q, dispq_q, dispr_q, valid_q);
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (dbus.done) begin
                    bq_d    = dbus.cociente;
                    br_d    = dbus.resto;
                    bcdq_d  = '0;
                    bcdr_d  = '0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcdq_d = step_q[18:7];
                bq_d   = step_q[6:0];
                bcdr_d = step_r[18:7];
                br_d   = step_r[6:0];
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = ST_LOAD;
                end
                if (dbus.done) begin
                    pend_d = 1'b1;
                    pq_d   = dbus.cociente;
                    pr_d   = dbus.resto;
                end
            end
            ST_LOAD: begin
                dispq_d = bcdq_q;
                dispr_d = bcdr_q;
                valid_d = 1'b1;
                // A strobe arriving during LOAD is newer than anything pending.
                if (dbus.done || pend_q) begin
                    bq_d    = dbus.done ? dbus.cociente : pq_q;
                    br_d    = dbus.done ? dbus.resto    : pr_q;
                    pend_d  = 1'b0;
                    bcdq_d  = '0;
                    bcdr_d  = '0;
                    cnt_d   = 3'd0;
                    state_d = ST_CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bq_q    <= '0;
            br_q    <= '0;
            bcdq_q  <= '0;
            bcdr_q  <= '0;
            dispq_q <= '0;
            dispr_q <= '0;
            pend_q  <= 1'b0;
            pq_q    <= '0;
            pr_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ref_q   <= '0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 6'h3F;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bq_q    <= bq_d;
            br_q    <= br_d;
            bcdq_q  <= bcdq_d;
            bcdr_q  <= bcdr_d;
            dispq_q <= dispq_d;
            dispr_q <= dispr_d;
            pend_q  <= pend_d;
            pq_q    <= pq_d;
            pr_q    <= pr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ref_q   <= ref_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign dbus.seg   = seg_q;
    assign dbus.an    = an_q;
    assign dbus.busy  = busy_q;
    assign dbus.valid = valid_q;

endmodule

`default_nettype wire

// File: doc/resultado_bcd_display.md
# resultado_bcd_display

Downstream consumer of the 7-bit restoring divider. It captures `cociente`/`resto` on the divider's `done` pulse and converts each to three BCD digits with a sequential double-dabble engine. It then drives a 6-digit multiplexed common-anode 7-segment display: quotient on the upper three digits, remainder on the lower three.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cociente`  in  7  quotient from divider; sampled only when `done`=1.
- `resto`  in  7  remainder from divider; sampled only when `done`=1.
- `done`  in  1  single-cycle result strobe from divider.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  6  digit enables, active-low one-hot, registered; `an[0]` is the rightmost digit.
- `busy`  out  1  conversion in progress.
- `valid`  out  1  display holds at least one converted result; sticky until reset.

## Operation
- FSM states are IDLE, CONV and LOAD.
- **IDLE + `done`:**
  - latch `cociente`→`bq` and `resto`→`br`;
  - clear both 12-bit BCD registers;
  - `cnt`←0, `busy`←1, go to CONV.
- **CONV (7 cycles, `cnt` 0..6), per cycle:**
  - every BCD nibble ≥5 gets +3;
  - then shift {bcd, bin} left by 1;
  - both values are processed in parallel;
  - at `cnt`=6, go to LOAD.
- **LOAD:**
  - copy both BCD registers into the display registers;
  - `valid`←1.
  - If a pending flag is set: clear it, latch the pending operands, re-enter CONV (`busy` stays 1).
  - Otherwise `busy`←0 and go to IDLE.
- **`done` while in CONV or LOAD:**
  - operands go to a one-deep pending buffer and the pending flag is set;
  - a later `done` overwrites the pending operands (last wins).
- **Digit map:**
  - `an[5..3]` = quotient hundreds/tens/units;
  - `an[2..0]` = remainder hundreds/tens/units.
- **Leading-zero blanking** applies per 3-digit group: a blanked digit drives `seg`=7'h7F.
  - Hundreds digit is blanked if 0.
  - Tens digit is blanked if it and hundreds are both 0.
  - Units digit is never blanked.
- **Segment codes (hex):** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. BCD values 10–15 are unreachable; they decode to 7F.
- **Before the first LOAD** (`valid`=0): `seg`=7F on every digit; scanning still runs.
- **Refresh counter:**
  - counts 0..`REFRESH_DIV`-1;
  - on wrap, digit index increments 0→5→0;
  - `an` ← ~(1 << index) and `seg` ← code for that digit, both registered together;
  - scanning is independent of FSM state.

## Timing
- **Reset values:**
  - `seg`=7'h7F, `an`=6'h3F, `busy`=0, `valid`=0;
  - FSM=IDLE; refresh counter, digit index, pending flag and display registers all 0.
- `rst` low at any time, including mid-CONV, aborts immediately and discards the pending operands. Operation resumes on the first edge after `rst` rises.
- **Latency, with `done` sampled at edge E0:**
  - `busy`=1 after E0;
  - CONV spans E1..E7;
  - LOAD at E8: display registers and `valid` update after E8, `busy`=0 after E8;
  - new digits reach `seg` on the next scan update of each digit.
- Back-to-back results: the second LOAD lands 8 edges after the first.
- `an` first goes active (111110) one edge after the refresh counter first wraps following reset. Each digit is then held exactly `REFRESH_DIV` cycles.
- Display registers change only in LOAD, so `seg` never shows a partially converted value.

## Test plan
- **Reset:** hold `rst`=0 with toggling inputs → `seg`=7F, `an`=3F, `busy`=0, `valid`=0. Release, then pulse `done` → conversion proceeds normally.
- **Max value:** `cociente`=127, `resto`=0, `done` pulse → `busy`=1 for 8 cycles, `valid`=1 after E8. Digits 5..0 = 79, 24, 78, 7F, 7F, 40.
- **Leading zeros:** `cociente`=14, `resto`=5 → digits 5..0 = 7F, 79, 19, 7F, 7F, 12. `cociente`=0, `resto`=100 → 7F, 7F, 40, 79, 40, 40.
- **Pending buffer:**
  - pulse `done` (q=9, r=3);
  - 3 cycles later pulse `done` (q=64, r=1) → first result loads at E8, `busy` stays 1, second loads at E16 with digits 7F, 02, 19, 7F, 7F, 79;
  - a third `done` during the same CONV replaces the pending operands.
- **Scan (`REFRESH_DIV`=4):** `an` steps 111110→111101→…→011111→111110. Each value is held 4 cycles, and `seg` matches the digit selected by `an` every cycle.
- **Reset mid-CONV:** `rst`=0 at E4 → `busy`=0 and `valid` stays at its reset value 0. Display registers stay at 0 and `seg` remains 7F.
